muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit implementing the RISC-V M-extension operations. It sits beside the single-cycle `alu` in the execute stage: the datapath issues one request over a valid/ready handshake, the unit iterates one bit per cycle, and it holds the result until the consumer accepts it. Divide-by-zero and signed overflow finish early with the ISA-defined results.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width, ≥ 4.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of any in-flight or held operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept (high only in IDLE).
- `req_op`  in  `muldiv_ops` (3)  operation.
- `req_a`, `req_b`  in  WIDTH  rs1 / rs2 operands.
- `resp_valid`  out  1  result held.
- `resp_ready`  in  1  consumer takes result.
- `resp_result`  out  WIDTH  result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op and operands.
  - If the op is div/divu/rem/remu with b==0, or div/rem with a=MIN_SIGNED and b=−1, load the special result and go to DONE. Otherwise go to CALC with counter=WIDTH−1.
- Special results:
  - Divide by zero: div/divu give all-ones; rem/remu give a.
  - Signed overflow: div gives MIN_SIGNED; rem gives 0.
- CALC runs WIDTH cycles on operand magnitudes:
  - Magnitude = two's-complement negation for signed-negative operands.
  - mulhsu treats b as unsigned.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and a WIDTH-bit remainder.
  - At counter==0 go to FIX.
- FIX, one cycle:
  - Multiply: negate the 2·WIDTH product if the operand signs differ (signed ops only). mul selects the low half; mulh, mulhsu and mulhu select the high half.
  - div: negate the quotient if the signs differ. rem: the remainder takes the sign of a.
  - Register the result, then go to DONE.
- DONE:
  - `resp_valid`=1 and `resp_result` is stable.
  - On `resp_ready`, go to IDLE. `req_ready` stays 0 in DONE.
- `flush` has priority over all transitions: next state is IDLE, the result is discarded, and no response is produced. `flush` together with `req_valid` in IDLE accepts nothing.
- Width rules: all arithmetic is modulo 2^WIDTH, except the 2·WIDTH product and the WIDTH+1-bit partial remainder.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_result`=0, counter=0.
- Reset mid-operation clears all state immediately, with no response.
- Normal latency: the accept edge is cycle 0; `resp_valid` rises after edge WIDTH+2 (34 cycles for WIDTH=32).
- Special-case latency: `resp_valid` rises after edge 1.
- Throughput: at least one idle cycle between response handshake and next accept. Back-to-back with `resp_ready` held high gives one op per WIDTH+3 cycles.
- Outputs are registered or decoded from state only; there is no combinational path from `req_*` to `resp_*`.
- `resp_result` changes only on entry to DONE.

## Structure
- `muldiv_ops` enum lives in shared package `rv32i_types`, encoded as funct3: mul=000, mulh=001, mulhsu=010, mulhu=011, div=100, divu=101, rem=110, remu=111.
- State enum is local to the module.
- Single module, no sub-modules; it stays separate from `alu`.

## Test plan
WIDTH=32.
- mul a=7, b=0xFFFFFFFD → 0xFFFFFFEB, with `resp_valid` exactly 34 cycles after accept.
- mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×2 → 0xFFFFFFFF.
- div 0xFFFFFFF9/2 → 0xFFFFFFFD; rem gives 0xFFFFFFFF; divu 0xFFFFFFFF/2 → 0x7FFFFFFF; remu 100/7 → 2.
- div 5/0 → 0xFFFFFFFF and rem 5/0 → 5, both with 1-cycle latency. div 0x80000000/0xFFFFFFFF → 0x80000000; rem gives 0.
- Hold `resp_ready`=0 for 5 cycles in DONE: result stable, `req_ready`=0, single response on release.
- `flush` at CALC cycle 10 → IDLE next cycle, no response. Async reset at CALC cycle 20 → reset values at once; a following request completes correctly.

Source files
------------

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package    : rv32i_types
// Purpose    : Shared execute-stage types. muldiv_ops is encoded as the
//              RISC-V M-extension funct3, so the decoder can pass funct3 through.
//              Bit 2 set = divide family; bit 1 set within it = remainder.
// Revision   : 1.0 - initial release
// ============================================================================
package rv32i_types;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_ops;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module     : muldiv_unit
// Purpose    : Iterative RISC-V M-extension multiply/divide, one bit per cycle.
//              Accepts one request over valid/ready, iterates on operand
//              magnitudes, fixes signs, then holds the result until taken.
//              Divide-by-zero and signed overflow bypass the iteration.
// Ports      : clk          - clock, rising edge
//              rst          - asynchronous active-low reset
//              flush        - synchronous kill of in-flight / held operation
//              req_valid    - request present
//              req_ready    - unit idle, can accept
//              req_op       - operation (funct3 encoding)
//              req_a/req_b  - rs1 / rs2 operands
//              resp_valid   - result held
//              resp_ready   - consumer takes result
//              resp_result  - result
// Revision   : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_ops        req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_SIGNED = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Registered operation context
  muldiv_ops        op_q;
  logic             a_neg_q, b_neg_q;
  logic [WIDTH-1:0] opnd_q;   // multiplicand (mul) or divisor (div)
  logic [2*WIDTH-1:0] acc_q;  // mul: {product hi, multiplier/product lo}; div: {remainder, quotient}
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;

  // ---------------- Request decode ----------------
  logic             is_div, a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_result;
  logic             accept;

  assign is_div   = req_op[2];
  assign a_signed = (req_op == MULH) || (req_op == MULHSU) || (req_op == DIV) || (req_op == REM);
  assign b_signed = (req_op == MULH) || (req_op == DIV) || (req_op == REM);
  assign a_neg    = a_signed && req_a[WIDTH-1];
  assign b_neg    = b_signed && req_b[WIDTH-1];
  assign mag_a    = a_neg ? -req_a : req_a;
  assign mag_b    = b_neg ? -req_b : req_b;

  assign div_zero = is_div && (req_b == '0);
  assign div_ovf  = ((req_op == DIV) || (req_op == REM)) && (req_a == MIN_SIGNED) && (req_b == '1);
  assign special  = div_zero || div_ovf;

  // req_op[1] separates remainder ops from quotient ops within the divide family
  always_comb begin
    special_result = '0;
    if (div_zero)
      special_result = req_op[1] ? req_a : '1;
    else if (div_ovf)
      special_result = req_op[1] ? '0 : MIN_SIGNED;
  end

  assign accept = (state == S_IDLE) && req_valid && !flush;

  // ---------------- Iteration step ----------------
  // Multiply: conditionally add multiplicand into the high half, then shift
  // the whole accumulator right; the carry enters at the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: shift next dividend bit into the partial remainder and
  // subtract the divisor when it fits. Since remainder < divisor, the
  // difference always fits back into WIDTH bits.
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  // ---------------- Sign fix-up ----------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_result;
  assign prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;

  always_comb begin
    fix_result = '0;
    case (op_q)
      MUL:                 fix_result = prod_fix[WIDTH-1:0];
      MULH, MULHSU, MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      DIV, DIVU:           fix_result = (a_neg_q ^ b_neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      REM, REMU:           fix_result = a_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      default:             fix_result = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = special ? S_DONE : S_CALC;
      end
      S_CALC:  if (cnt_q == '0) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      opnd_q  <= is_div ? mag_b : mag_a;
      acc_q   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      cnt_q   <= CNT_W'(WIDTH - 1);
      if (special) result_q <= special_result;
    end else if ((state == S_CALC) && !flush) begin
      acc_q <= op_q[2] ? div_next : mul_next;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end else if ((state == S_FIX) && !flush) begin
      result_q <= fix_result;
    end
  end

  assign resp_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_muldiv_unit
// Purpose    : Directed self-checking bench for muldiv_unit (WIDTH=32).
//              Latency is counted in rising edges including the accept edge.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  muldiv_ops   req_op = MUL;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one request; returns result and edges from accept (inclusive) to
  // resp_valid. lat==100 means the response never came.
  task automatic run_op(input muldiv_ops op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard = 0;
    while (!req_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    res = resp_result;
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL reset_resp_result: got %h want 0", resp_result); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    muldiv_ops   ops [5] = '{MUL, MULH, MULHU, MULHSU, MUL};
    logic [31:0] av  [5] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678};
    logic [31:0] bv  [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'h10};
    logic [31:0] ev  [5] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h23456780};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], res, lat);
      n_cmp++; if (res !== ev[i]) begin n_err++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, ev[i]); end
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL mul_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_divide();
    muldiv_ops   ops [6] = '{DIV, REM, DIVU, REMU, DIV, REM};
    logic [31:0] av  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd100, 32'd100, 32'd100};
    logic [31:0] bv  [6] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] ev  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFF2, 32'd2};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], av[i], bv[i], res, lat);
      n_cmp++; if (res !== ev[i]) begin n_err++; $display("FAIL div_result[%0d]: got %h want %h", i, res, ev[i]); end
      n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL div_latency[%0d]: got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_special();
    muldiv_ops   ops [6] = '{DIV, REM, DIVU, REMU, DIV, REM};
    logic [31:0] av  [6] = '{32'd5, 32'd5, 32'd9, 32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev  [6] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], av[i], bv[i], res, lat);
      n_cmp++; if (res !== ev[i]) begin n_err++; $display("FAIL special_result[%0d]: got %h want %h", i, res, ev[i]); end
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    int lat;
    int extra = 0;
    resp_ready = 1'b0;
    run_op(DIVU, 32'd100, 32'd7, res, lat);
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL hold_latency: got %0d want 34", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b want 1", i, resp_valid); end
      n_cmp++; if (resp_result !== 32'd14) begin n_err++; $display("FAIL hold_result[%0d]: got %h want %h", i, resp_result, 32'd14); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", req_ready); end
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) extra++;
      @(posedge clk); #1;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL hold_single_resp: got %0d extra cycles want 0", extra); end
  endtask

  task automatic test_flush();
    int seen = 0;
    req_op = MUL; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL flush_idle: got req_ready %b want 1", req_ready); end
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_no_resp: got %0d resp cycles want 0", seen); end
    // flush together with a request in IDLE must accept nothing
    seen = 0;
    req_op = DIV; req_a = 32'd5; req_b = 32'd0; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid || !req_ready) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_idle_accept: got %0d busy cycles want 0", seen); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    int lat;
    req_op = MULHU; req_a = 32'hFFFFFFFF; req_b = 32'hFFFFFFFF; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL areset_req_ready: got %b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL areset_resp_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_result !== 32'h0) begin n_err++; $display("FAIL areset_resp_result: got %h want 0", resp_result); end
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat);
    n_cmp++; if (res !== 32'h0) begin n_err++; $display("FAIL areset_after_result: got %h want 0", res); end
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL areset_after_latency: got %0d want 34", lat); end
  endtask

  task automatic test_back_to_back();
    int acc_edge [2];
    int na = 0;
    int e = 0;
    int lat = 0;
    logic will_acc;
    resp_ready = 1'b1;
    req_op = MUL; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    while (na < 2 && e < 200) begin
      will_acc = req_ready;
      @(posedge clk); #1; e++;
      if (will_acc) begin acc_edge[na] = e; na++; end
    end
    req_valid = 1'b0;
    n_cmp++; if (na !== 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", na); end
    else begin
      n_cmp++; if (acc_edge[1] - acc_edge[0] !== 35) begin n_err++; $display("FAIL b2b_period: got %0d want 35", acc_edge[1] - acc_edge[0]); end
    end
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (resp_result !== 32'd15 || !resp_valid) begin n_err++; $display("FAIL b2b_result: got %h valid %b want %h", resp_result, resp_valid, 32'd15); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_special();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
